// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with HI/LO registers, single-cycle multiply and iterative radix-2 divider
module alu_exec #(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluopE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic [4:0]  saE,
  input  logic        stallE,
  input  logic        flushE,
  output logic [31:0] resultE,
  output logic        overflowE,
  output logic        div_stallE,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam logic [7:0] OP_AND   = 8'd1;
  localparam logic [7:0] OP_OR    = 8'd2;
  localparam logic [7:0] OP_XOR   = 8'd3;
  localparam logic [7:0] OP_NOR   = 8'd4;
  localparam logic [7:0] OP_LUI   = 8'd5;
  localparam logic [7:0] OP_ADD   = 8'd6;
  localparam logic [7:0] OP_ADDU  = 8'd7;
  localparam logic [7:0] OP_SUB   = 8'd8;
  localparam logic [7:0] OP_SUBU  = 8'd9;
  localparam logic [7:0] OP_SLT   = 8'd10;
  localparam logic [7:0] OP_SLTU  = 8'd11;
  localparam logic [7:0] OP_SLL   = 8'd12;
  localparam logic [7:0] OP_SRL   = 8'd13;
  localparam logic [7:0] OP_SRA   = 8'd14;
  localparam logic [7:0] OP_SLLV  = 8'd15;
  localparam logic [7:0] OP_SRLV  = 8'd16;
  localparam logic [7:0] OP_SRAV  = 8'd17;
  localparam logic [7:0] OP_MULT  = 8'd18;
  localparam logic [7:0] OP_MULTU = 8'd19;
  localparam logic [7:0] OP_DIV   = 8'd20;
  localparam logic [7:0] OP_DIVU  = 8'd21;
  localparam logic [7:0] OP_MFHI  = 8'd22;
  localparam logic [7:0] OP_MFLO  = 8'd23;
  localparam logic [7:0] OP_MTHI  = 8'd24;
  localparam logic [7:0] OP_MTLO  = 8'd25;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(DIV_STEPS);
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_quo, r_rem, r_dvs, r_orig, r_hi, r_lo;
  logic          r_neg_q, r_neg_r, r_dvz;
  logic [31:0]   w_add, w_sub, w_abs_a, w_abs_b, w_q_fix, w_r_fix;
  logic [63:0]   w_smul, w_umul;
  logic [32:0]   w_shift, w_diff;
  logic          w_sgn, w_start, w_we, w_commit;
  assign w_add    = srcaE + srcbE;
  assign w_sub    = srcaE - srcbE;
  assign w_smul   = {{32{srcaE[31]}}, srcaE} * {{32{srcbE[31]}}, srcbE};
  assign w_umul   = {32'd0, srcaE} * {32'd0, srcbE};
  assign w_sgn    = aluopE == OP_DIV;
  assign w_abs_a  = (w_sgn & srcaE[31]) ? -srcaE : srcaE;
  assign w_abs_b  = (w_sgn & srcbE[31]) ? -srcbE : srcbE;
  assign w_start  = r_state == S_IDLE & (aluopE == OP_DIV | aluopE == OP_DIVU) & !flushE;
  assign div_stallE = w_start | (r_state == S_RUN & !flushE);
  assign w_we     = !stallE & !flushE & !div_stallE;
  assign w_commit = r_state == S_DONE & !stallE & !flushE;
  assign w_shift  = {r_rem, r_quo[31]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign w_q_fix  = r_neg_q ? -r_quo : r_quo;
  assign w_r_fix  = r_neg_r ? -r_rem : r_rem;
  assign overflowE = (aluopE == OP_ADD & srcaE[31] == srcbE[31] & w_add[31] != srcaE[31]) |
                     (aluopE == OP_SUB & srcaE[31] != srcbE[31] & w_sub[31] != srcaE[31]);
  assign hi_o = r_hi;
  assign lo_o = r_lo;
  // combinational result select; unknown codes yield zero
  always_comb begin
    resultE = 32'd0;
    case (aluopE)
      OP_AND:  resultE = srcaE & srcbE;
      OP_OR:   resultE = srcaE | srcbE;
      OP_XOR:  resultE = srcaE ^ srcbE;
      OP_NOR:  resultE = ~(srcaE | srcbE);
      OP_LUI:  resultE = {srcbE[15:0], 16'h0};
      OP_ADD, OP_ADDU: resultE = w_add;
      OP_SUB, OP_SUBU: resultE = w_sub;
      OP_SLT:  resultE = {31'd0, $signed(srcaE) < $signed(srcbE)};
      OP_SLTU: resultE = {31'd0, srcaE < srcbE};
      OP_SLL:  resultE = srcbE << saE;
      OP_SRL:  resultE = srcbE >> saE;
      OP_SRA:  resultE = $signed(srcbE) >>> saE;
      OP_SLLV: resultE = srcbE << srcaE[4:0];
      OP_SRLV: resultE = srcbE >> srcaE[4:0];
      OP_SRAV: resultE = $signed(srcbE) >>> srcaE[4:0];
      OP_MFHI: resultE = r_hi;
      OP_MFLO: resultE = r_lo;
      default: resultE = 32'd0;
    endcase
  end
  // divider FSM: latch magnitudes, run one restoring step per cycle, wait in DONE for the pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_orig  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dvz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_quo   <= w_abs_a;
          r_dvs   <= w_abs_b;
          r_rem   <= '0;
          r_cnt   <= '0;
          r_orig  <= srcaE;
          r_neg_q <= w_sgn & (srcaE[31] ^ srcbE[31]);
          r_neg_r <= w_sgn & srcaE[31];
          r_dvz   <= srcbE == 32'd0;
          r_state <= S_RUN;
        end
        S_RUN: if (flushE) r_state <= S_IDLE;
        else begin
          r_rem   <= w_diff[32] ? w_shift[31:0] : w_diff[31:0];
          r_quo   <= {r_quo[30:0], !w_diff[32]};
          r_cnt   <= r_cnt + 1'b1;
          r_state <= r_cnt == CW'(DIV_STEPS - 1) ? S_DONE : S_RUN;
        end
        S_DONE: if (flushE | !stallE) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // HI/LO: divider commit has priority, otherwise multiply and move-to writes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_lo <= r_dvz ? 32'hFFFF_FFFF : w_q_fix;
      r_hi <= r_dvz ? r_orig : w_r_fix;
    end else if (w_we) begin
      case (aluopE)
        OP_MULT:  {r_hi, r_lo} <= w_smul;
        OP_MULTU: {r_hi, r_lo} <= w_umul;
        OP_MTHI:  r_hi <= srcaE;
        OP_MTLO:  r_lo <= srcaE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec with directed vectors
module tb_alu_exec;
  localparam logic [7:0] OP_AND = 8'd1, OP_OR = 8'd2, OP_XOR = 8'd3, OP_NOR = 8'd4, OP_LUI = 8'd5;
  localparam logic [7:0] OP_ADD = 8'd6, OP_ADDU = 8'd7, OP_SUB = 8'd8, OP_SLT = 8'd10, OP_SLTU = 8'd11;
  localparam logic [7:0] OP_SRL = 8'd13, OP_SRA = 8'd14, OP_SLLV = 8'd15, OP_SRAV = 8'd17;
  localparam logic [7:0] OP_MULT = 8'd18, OP_MULTU = 8'd19, OP_DIV = 8'd20, OP_DIVU = 8'd21;
  localparam logic [7:0] OP_MFHI = 8'd22, OP_MFLO = 8'd23, OP_MTHI = 8'd24, OP_MTLO = 8'd25;
  localparam int K_RES = 0, K_OVF = 1, K_HI = 2, K_LO = 3, K_STALL = 4, K_CNT = 5;
  logic clk = 0, rst = 1, stallE = 0, flushE = 0;
  logic [7:0] aluopE = 0;
  logic [31:0] srcaE = 0, srcbE = 0;
  logic [4:0] saE = 0;
  logic [31:0] resultE, hi_o, lo_o;
  logic overflowE, div_stallE;
  int total = 0, bad = 0, meas = 0, n;
  int q_kind[$];
  logic [31:0] q_exp[$];
  string q_name[$];
  int m_k;
  logic [31:0] m_e, m_a;
  string m_n;
  alu_exec dut (.clk(clk), .rst(rst), .aluopE(aluopE), .srcaE(srcaE), .srcbE(srcbE), .saE(saE),
    .stallE(stallE), .flushE(flushE), .resultE(resultE), .overflowE(overflowE),
    .div_stallE(div_stallE), .hi_o(hi_o), .lo_o(lo_o));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input int k, input logic [31:0] e, input string nm);
    q_kind.push_back(k);
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask
  task automatic set(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sa);
    aluopE = op;
    srcaE = a;
    srcbE = b;
    saE = sa;
  endtask
  task automatic alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sa,
                     input logic [31:0] er, input logic eo, input string nm);
    set(op, a, b, sa);
    chk(K_RES, er, nm);
    chk(K_OVF, {31'd0, eo}, {nm, "_ovf"});
    step();
  endtask
  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, output int cnt);
    set(op, a, b, 0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!div_stallE) break;
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) begin
    while (q_kind.size() > 0) begin
      m_k = q_kind.pop_front();
      m_e = q_exp.pop_front();
      m_n = q_name.pop_front();
      m_a = m_k == K_RES ? resultE : m_k == K_OVF ? {31'd0, overflowE} : m_k == K_HI ? hi_o :
            m_k == K_LO ? lo_o : m_k == K_STALL ? {31'd0, div_stallE} : meas;
      total++;
      if (m_a !== m_e) begin
        bad++;
        $display("FAIL %s: got %h expected %h", m_n, m_a, m_e);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    step();
    step();
    rst = 0;
    chk(K_RES, 0, "rst_res");
    chk(K_OVF, 0, "rst_ovf");
    chk(K_HI, 0, "rst_hi");
    chk(K_LO, 0, "rst_lo");
    chk(K_STALL, 0, "rst_stall");
    step();
    alu(OP_ADD, 32'h7FFFFFFF, 32'd1, 0, 32'h80000000, 1, "add_ovf");
    alu(OP_ADDU, 32'h7FFFFFFF, 32'd1, 0, 32'h80000000, 0, "addu");
    alu(OP_SUB, 32'h80000000, 32'd1, 0, 32'h7FFFFFFF, 1, "sub_ovf");
    alu(OP_SUB, 32'd5, 32'd7, 0, 32'hFFFFFFFE, 0, "sub");
    alu(OP_SRA, 32'd0, 32'h80000000, 5'd4, 32'hF8000000, 0, "sra");
    alu(OP_SRL, 32'd0, 32'h80000000, 5'd31, 32'd1, 0, "srl");
    alu(OP_SLLV, 32'd4, 32'd1, 0, 32'h10, 0, "sllv");
    alu(OP_SRAV, 32'd36, 32'h80000000, 0, 32'hF8000000, 0, "srav");
    alu(OP_SLTU, 32'd1, 32'hFFFFFFFF, 0, 32'd1, 0, "sltu");
    alu(OP_SLT, 32'd1, 32'hFFFFFFFF, 0, 32'd0, 0, "slt");
    alu(OP_LUI, 32'd0, 32'h1234, 0, 32'h12340000, 0, "lui");
    alu(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hF000F000, 0, "and");
    alu(OP_OR, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hFFF0FFF0, 0, "or");
    alu(OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h0FF00FF0, 0, "xor");
    alu(OP_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h000F000F, 0, "nor");
    alu(8'hFF, 32'h12345678, 32'h1, 0, 32'd0, 0, "unknown");
    set(OP_MULT, 32'hFFFFFFFD, 32'd5, 0);
    step();
    set(OP_MFLO, 0, 0, 0);
    chk(K_RES, 32'hFFFFFFF1, "mflo");
    chk(K_HI, 32'hFFFFFFFF, "mult_hi");
    chk(K_LO, 32'hFFFFFFF1, "mult_lo");
    step();
    set(OP_MULTU, 32'hFFFFFFFF, 32'd2, 0);
    step();
    set(OP_MFHI, 0, 0, 0);
    chk(K_RES, 32'd1, "mfhi");
    chk(K_LO, 32'hFFFFFFFE, "multu_lo");
    step();
    stallE = 1;
    set(OP_MULT, 32'd2, 32'd3, 0);
    step();
    stallE = 0;
    set(0, 0, 0, 0);
    chk(K_HI, 32'd1, "mult_stalled_hi");
    chk(K_LO, 32'hFFFFFFFE, "mult_stalled_lo");
    step();
    run_div(OP_DIV, 32'hFFFFFFF9, 32'd2, n);
    step();
    meas = n;
    set(0, 0, 0, 0);
    chk(K_CNT, 33, "div_stall_cycles");
    chk(K_LO, 32'hFFFFFFFD, "div_lo");
    chk(K_HI, 32'hFFFFFFFF, "div_hi");
    chk(K_STALL, 0, "div_idle");
    step();
    run_div(OP_DIVU, 32'd100, 32'd7, n);
    step();
    meas = n;
    set(0, 0, 0, 0);
    chk(K_CNT, 33, "divu_stall_cycles");
    chk(K_LO, 32'd14, "divu_lo");
    chk(K_HI, 32'd2, "divu_hi");
    step();
    run_div(OP_DIVU, 32'h55, 32'd0, n);
    step();
    meas = n;
    set(0, 0, 0, 0);
    chk(K_CNT, 33, "dz_stall_cycles");
    chk(K_LO, 32'hFFFFFFFF, "dz_lo");
    chk(K_HI, 32'h55, "dz_hi");
    step();
    set(OP_MTHI, 32'hA5A5A5A5, 0, 0);
    step();
    set(OP_MTLO, 32'h5A5A5A5A, 0, 0);
    step();
    set(OP_DIV, 32'hFFFFFFF9, 32'd2, 0);
    step();
    repeat (9) step();
    chk(K_STALL, 1, "run_stall");
    step();
    flushE = 1;
    chk(K_STALL, 0, "flush_stall");
    step();
    flushE = 0;
    set(0, 0, 0, 0);
    chk(K_STALL, 0, "flush_idle");
    chk(K_HI, 32'hA5A5A5A5, "flush_hi");
    chk(K_LO, 32'h5A5A5A5A, "flush_lo");
    step();
    set(OP_DIVU, 32'd100, 32'd7, 0);
    step();
    repeat (20) step();
    rst = 1;
    step();
    rst = 0;
    set(0, 0, 0, 0);
    chk(K_HI, 0, "rstmid_hi");
    chk(K_LO, 0, "rstmid_lo");
    chk(K_STALL, 0, "rstmid_stall");
    step();
    stallE = 1;
    run_div(OP_DIVU, 32'd100, 32'd7, n);
    meas = n;
    step();
    chk(K_CNT, 33, "hold_stall_cycles");
    chk(K_LO, 0, "hold_lo_1");
    chk(K_STALL, 0, "hold_nostall");
    step();
    chk(K_LO, 0, "hold_lo_2");
    step();
    stallE = 0;
    chk(K_HI, 0, "hold_hi_3");
    step();
    set(0, 0, 0, 0);
    chk(K_LO, 32'd14, "hold_lo_final");
    chk(K_HI, 32'd2, "hold_hi_final");
    step();
    step();
    if (hi_o !== 32'd2) begin
      bad++;
      $display("FAIL end_hi: got %h", hi_o);
    end
    if (lo_o !== 32'd14) begin
      bad++;
      $display("FAIL end_lo: got %h", lo_o);
    end
    if (div_stallE !== 1'b0) begin
      bad++;
      $display("FAIL end_stall: got %b", div_stallE);
    end
    if (total < 12) begin
      bad++;
      $display("FAIL too few checks: %0d", total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad != 0) $fatal(1, "FAIL");
    $display("PASS");
    $finish;
  end
endmodule
